// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate neuron stage: N (weight, activation) beats plus a
// bias produce one saturated pre-activation value for the activation stage.

`ifndef NEURON_MAC_TYPES
`define NEURON_MAC_TYPES
typedef enum logic [1:0] {
  INT = 2'd0,
  FXP = 2'd1,
  FLP = 2'd2
} dtype_t;

typedef struct packed {
  dtype_t     dtype;
  logic       sign;
  logic [7:0] prec;
} dconf_t;
`endif

`ifndef DEF_DCONF
`define DEF_DCONF '{dtype: FXP, sign: 1'b1, prec: 8'd8}
`endif

module neuron_mac #(
  parameter dconf_t CONF = `DEF_DCONF,
  parameter int     PREC = int'(CONF.prec),
  parameter int     FRAC = 0,
  parameter int     N    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [PREC-1:0] in_w,
  input  logic signed [PREC-1:0] in_x,
  input  logic signed [PREC-1:0] in_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [PREC-1:0] out_data
);

  localparam int ACCW = 2*PREC + $clog2(N) + 2;
  localparam int FS   = (CONF.dtype == INT) ? 0 : FRAC;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(N-1);

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-PREC+1){1'b0}}, {(PREC-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-PREC+1){1'b1}}, {(PREC-1){1'b0}}};
  localparam logic signed [PREC-1:0] OUT_MAX = {1'b0, {(PREC-1){1'b1}}};
  localparam logic signed [PREC-1:0] OUT_MIN = {1'b1, {(PREC-1){1'b0}}};

  generate
    if (!((CONF.dtype == FXP || CONF.dtype == INT) && CONF.sign == 1'b1)) begin : g_bad_conf
      $error("neuron_mac: only signed FXP or INT formats are supported");
    end
    if (N < 1) begin : g_bad_n
      $error("neuron_mac: N must be at least 1");
    end
    if (FS >= PREC) begin : g_bad_frac
      $error("neuron_mac: FRAC must be smaller than PREC");
    end
  endgenerate

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNTW-1:0]         cnt;
  logic signed [ACCW-1:0]  acc;
  logic signed [PREC-1:0]  bias_q;

  logic                    accept;
  logic                    first;
  logic                    last;
  logic signed [2*PREC-1:0] product;
  logic signed [PREC-1:0]  bias_sel;
  logic signed [ACCW-1:0]  bias_ext;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [ACCW-1:0]  total;
  logic signed [ACCW-1:0]  scaled;
  logic signed [PREC-1:0]  sat_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  // The first beat of a group starts from zero rather than the stale sum, and
  // uses its own bias so that N==1 works without a separate path.
  always_comb begin
    accept   = in_valid && in_ready;
    first    = (cnt == '0);
    last     = (cnt == LAST);
    product  = in_w * in_x;
    acc_sum  = (first ? '0 : acc) + {{(ACCW-2*PREC){product[2*PREC-1]}}, product};
    bias_sel = first ? in_bias : bias_q;
    bias_ext = {{(ACCW-PREC){bias_sel[PREC-1]}}, bias_sel};
    total    = acc_sum + (bias_ext <<< FS);
    scaled   = total >>> FS;
    if (scaled > SAT_MAX) begin
      sat_val = OUT_MAX;
    end else if (scaled < SAT_MIN) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = scaled[PREC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      bias_q   <= '0;
      out_data <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      if (first) begin
        bias_q <= in_bias;
      end
      if (last) begin
        cnt      <= '0;
        out_data <= sat_val;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed groups from the test plan followed by random
// traffic, compared each cycle against a transaction-level integer model.

module tb_neuron_mac;

  localparam int PREC = 8;
  localparam int FRAC = 4;
  localparam int N    = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [PREC-1:0] in_w = '0;
  logic signed [PREC-1:0] in_x = '0;
  logic signed [PREC-1:0] in_bias = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [PREC-1:0] out_data;

  int   checkCount = 0;
  int   passCount  = 0;

  // Model state: beats so far, running sum of products, group bias, result.
  int   mCnt;
  int   mSum;
  int   mBias;
  int   mData;
  logic mValid;

  neuron_mac #(.FRAC(FRAC), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_w     (in_w),
    .in_x     (in_x),
    .in_bias  (in_bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int saturate(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Drive one cycle, check outputs mid-cycle, then advance the model past the edge.
  task automatic applyStimulus(input logic v, input int w, input int x, input int b,
                               input logic ordy, input logic rst);
    int total;
    in_valid  = v;
    in_w      = PREC'(w);
    in_x      = PREC'(x);
    in_bias   = PREC'(b);
    out_ready = ordy;
    reset     = rst;
    @(negedge clk);
    checkOutput("in_ready", 32'(in_ready), 32'(!mValid));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_data", 32'(out_data), mData);
    if (rst) begin
      mCnt = 0; mSum = 0; mBias = 0; mData = 0; mValid = 1'b0;
    end else if (mValid) begin
      if (ordy) mValid = 1'b0;
    end else if (v) begin
      if (mCnt == 0) begin
        mBias = int'(in_bias);
        mSum  = 0;
      end
      mSum += int'(in_w) * int'(in_x);
      mCnt++;
      if (mCnt == N) begin
        total  = mSum + mBias * (1 << FRAC);
        mData  = saturate(total >>> FRAC);
        mValid = 1'b1;
        mCnt   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendGroup(input int w, input int x, input int b);
    for (int i = 0; i < N; i++) applyStimulus(1'b1, w, x, b, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    mCnt = 0; mSum = 0; mBias = 0; mData = 0; mValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Basic group held under backpressure, with in_valid ignored while full.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 16, 16, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16, 16, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16, 16, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Floor rounding of a tiny negative sum and bias-only results.
    applyStimulus(1'b1, -1, 1, 0, 1'b1, 1'b0);
    for (int i = 1; i < N; i++) applyStimulus(1'b1, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    sendGroup(0, 0, 16);

    // Saturation in both directions.
    sendGroup(127, 127, 0);
    sendGroup(-128, 127, 0);

    // Bubbles while accumulating, then a long stall on the output.
    for (int i = 0; i < 2*N; i++) applyStimulus(i % 2 == 0, 16, 16, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5, 7, 3, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a group, then a clean group.
    applyStimulus(1'b1, 127, 127, 50, 1'b1, 1'b0);
    applyStimulus(1'b1, 127, 127, 50, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    sendGroup(16, 16, 0);

    // Only the first beat's bias counts.
    applyStimulus(1'b1, 0, 0, 16, 1'b1, 1'b0);
    for (int i = 1; i < N; i++) applyStimulus(1'b1, 0, 0, -128, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);

    // Reset while a result is pending.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 30, -20, 7, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) < 70,
                    int'($urandom_range(255)) - 128,
                    int'($urandom_range(255)) - 128,
                    int'($urandom_range(255)) - 128,
                    $urandom_range(99) < 60,
                    $urandom_range(199) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Streaming multiply-accumulate neuron stage that sits directly upstream of the activation stage (act_relu).
- It consumes N (weight, activation) pairs over a valid/ready handshake and accumulates the products at full precision.
- It adds a bias, rescales to the CONF fixed-point format, saturates, and presents one PREC-bit pre-activation value.
- out_data connects straight to the activation input.

Parameters:
- CONF, `DEF_DCONF, data format (dconf_t). Supported: dtype FXP or INT with sign=1. Any other combination is an elaboration error ($error).
- PREC, CONF.prec, element width in bits.
- FRAC, 0, fractional bits of FXP operands. Forced to 0 when dtype is INT. Must satisfy FRAC < PREC.
- N, 16, fan-in: products per output. Must satisfy N >= 1.
- ACCW, 2*PREC+$clog2(N)+2, accumulator width (derived, do not override).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_w/in_x/in_bias valid.
- in_ready  output  1  stage accepts an input beat.
- in_w  input  PREC  signed weight.
- in_x  input  PREC  signed activation.
- in_bias  input  PREC  signed bias in output format. Sampled only on the first beat of a group.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  PREC  signed saturated pre-activation result.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset state: state=ACC, cnt=0, acc=0, bias_q=0, out_valid=0, out_data=0, in_ready=1.
- A beat is accepted when in_valid && in_ready. An output is transferred when out_valid && out_ready.
- Two states, ACC and OUT.
- ACC state:
  - in_ready=1 and out_valid=0.
  - Each accepted beat does: acc <= acc + sext(in_w*in_x) (signed 2*PREC product), and cnt <= cnt+1.
  - On the beat where cnt==0, bias_q <= in_bias is captured, and acc is loaded with the product alone (not added to the stale acc).
  - On the beat where cnt==N-1:
    - final sum S = acc + product + (sext(bias_q-or-in_bias) <<< FRAC). When N==1, the in_bias of the same beat is used.
    - out_data <= sat(S >>> FRAC).
    - state <= OUT, cnt <= 0.
  - Cycles with in_valid=0 (bubbles) leave acc, cnt and bias_q unchanged.
- OUT state:
  - in_ready=0 and out_valid=1.
  - out_data and out_valid are held stable until out_ready=1.
  - On transfer: out_valid <= 0 and state <= ACC. acc is don't-care, because it is reloaded on the next first beat.
- Latency and throughput:
  - out_valid rises the cycle after the N-th beat is accepted.
  - Minimum period per result is N+1 cycles.
- Arithmetic:
  - All arithmetic is two's complement.
  - >>> is an arithmetic shift (floor, round toward -inf).
  - sat() clamps to the range [-2^(PREC-1), 2^(PREC-1)-1].
  - ACCW guarantees no accumulator overflow for any input sequence.
- Reset mid-group: the partial sum and count are discarded. The next accepted beat is treated as the first beat.
- Reset while in OUT: the pending result is dropped and out_valid=0 on the next cycle.
- in_valid asserted during OUT is ignored, because in_ready=0. Upstream must hold the beat.

Test Plan (PREC=8, FRAC=4, N=4, FXP signed; 1.0=16):
- Basic: 4 beats w=16,x=16,bias=0, back-to-back -> out_valid one cycle after 4th beat, out_data=64 (4.0), in_ready=0 while out_valid=1.
- Bias and floor rounding:
  - beats (w=-1,x=1),(0,0),(0,0),(0,0), bias=0 -> out_data=-1 (0xFF).
  - all-zero products with bias=16 -> out_data=16.
- Saturation:
  - 4×(w=127,x=127) -> sum 64516>>>4=4032 -> out_data=127.
  - 4×(w=-128,x=127) -> -4064 -> out_data=-128 (0x80).
- Backpressure and bubbles:
  - in_valid toggling 1/0 across 8 cycles, then out_ready held 0 for 5 cycles -> out_data stable at 64 throughout, in_ready=0, no extra beats consumed.
  - out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Reset mid-group: accept 2 beats of (127,127), assert reset 1 cycle, then 4 beats (16,16) bias=0 -> out_data=64. The stale sum and bias are not included. All outputs are at reset values in the cycle after reset.
- Bias sampling: first beat in_bias=16, later beats in_bias=-128 with products 0 -> out_data=16. Only the first-beat bias is used.
